// File: rtl/fp_wb_pkg.sv
// Shared types for the FP writeback path: register-address encoding, the
// writeback payload struct and the tracked-register predicate.
package fp_wb_pkg;

   localparam int FP_XLEN     = 32;
   localparam int FP_ADDR_W   = 6;
   localparam int FP_FLAG_BIT = 5;

   typedef struct packed {
      logic [FP_ADDR_W-1:0] rd;
      logic [FP_XLEN-1:0]   data;
   } fp_wb_t;

   // f0 is never tracked; integer-side addresses (flag bit clear) are ignored.
   function automatic logic is_tracked(input logic [FP_ADDR_W-1:0] addr);
      return addr[FP_FLAG_BIT] && (addr[FP_FLAG_BIT-1:0] != '0);
   endfunction

endpackage

// File: rtl/fp_wb_scoreboard_if.sv
// Issue, writeback-source and register-file write signals of the FP
// writeback scoreboard; master is the pipeline side, slave the scoreboard.
interface fp_wb_scoreboard_if import fp_wb_pkg::*; #(
   parameter int XLEN = FP_XLEN
);

   logic                 issue_valid;
   logic [FP_ADDR_W-1:0] issue_rd;
   logic [FP_ADDR_W-1:0] issue_rs1;
   logic [FP_ADDR_W-1:0] issue_rs2;
   logic                 issue_hazard;
   logic                 issue_fire;

   logic                 fpu_wb_valid;
   logic [FP_ADDR_W-1:0] fpu_wb_rd;
   logic [XLEN-1:0]      fpu_wb_data;
   logic                 fpu_wb_ready;

   logic                 ld_wb_valid;
   logic [FP_ADDR_W-1:0] ld_wb_rd;
   logic [XLEN-1:0]      ld_wb_data;

   logic                 fwb_en;
   logic [FP_ADDR_W-1:0] fwb_addr;
   logic [XLEN-1:0]      fwb_data;
   logic                 ld_overflow;
   logic [31:0]          busy_vec;

   modport master (
      output issue_valid, issue_rd, issue_rs1, issue_rs2,
      input  issue_hazard, issue_fire,
      output fpu_wb_valid, fpu_wb_rd, fpu_wb_data,
      input  fpu_wb_ready,
      output ld_wb_valid, ld_wb_rd, ld_wb_data,
      input  fwb_en, fwb_addr, fwb_data, ld_overflow, busy_vec
   );

   modport slave (
      input  issue_valid, issue_rd, issue_rs1, issue_rs2,
      output issue_hazard, issue_fire,
      input  fpu_wb_valid, fpu_wb_rd, fpu_wb_data,
      output fpu_wb_ready,
      input  ld_wb_valid, ld_wb_rd, ld_wb_data,
      output fwb_en, fwb_addr, fwb_data, ld_overflow, busy_vec
   );

endinterface

// File: rtl/fp_wb_fifo.sv
// Small synchronous FIFO of writeback payloads buffering FP load returns,
// which cannot be back-pressured. DEPTH must be a power of two, >= 2.
module fp_wb_fifo import fp_wb_pkg::*; #(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  fp_wb_t                 din,
   input  logic                   pop,
   output fp_wb_t                 dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fp_wb_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   cnt;
   logic            wr_en;
   logic            rd_en;

   assign full  = (cnt == CW'(DEPTH));
   assign empty = (cnt == '0);
   assign count = cnt;
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and count define
   // which entries are valid, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fp_wb_scoreboard.sv
// Sequences FPU results and buffered load returns onto the single FP
// register-file write port and tracks in-flight destinations for issue.
module fp_wb_scoreboard import fp_wb_pkg::*; #(
   parameter int XLEN          = FP_XLEN,
   parameter int LD_FIFO_DEPTH = 2,
   parameter int STARVE_LIM    = 4
) (
   input  logic                clk,
   input  logic                rst,
   fp_wb_scoreboard_if.slave   bus
);

   localparam int CNT_W    = $clog2(LD_FIFO_DEPTH) + 1;
   localparam int STARVE_W = $clog2(STARVE_LIM + 1);

   logic [31:0]          busy_q;
   logic [31:0]          busy_next;
   logic [STARVE_W-1:0]  starve_cnt;
   logic                 fwb_en_q;
   logic [FP_ADDR_W-1:0] fwb_addr_q;
   logic [XLEN-1:0]      fwb_data_q;
   logic                 ld_overflow_q;

   fp_wb_t               ld_in;
   fp_wb_t               ld_head;
   fp_wb_t               grant_wb;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CNT_W-1:0]     fifo_count;

   logic                 hazard;
   logic                 fire;
   logic                 starved;
   logic                 fpu_grant;
   logic                 ld_grant;
   logic                 wb_write;

   function automatic logic op_busy(input logic [FP_ADDR_W-1:0] addr,
                                    input logic [31:0]          busy);
      return is_tracked(addr) && busy[addr[FP_FLAG_BIT-1:0]];
   endfunction

   assign hazard = bus.issue_valid && (op_busy(bus.issue_rs1, busy_q) ||
                                       op_busy(bus.issue_rs2, busy_q) ||
                                       op_busy(bus.issue_rd,  busy_q));
   assign fire   = bus.issue_valid && !hazard;

   // Loads win by default; the FPU takes the port when no load is waiting or
   // after it has lost STARVE_LIM consecutive cycles.
   assign starved   = (starve_cnt == STARVE_W'(STARVE_LIM));
   assign fpu_grant = !rst && bus.fpu_wb_valid && ((fifo_count == '0) || starved);
   assign ld_grant  = !rst && !fpu_grant && !fifo_empty;
   assign fifo_pop  = ld_grant;
   assign fifo_push = bus.ld_wb_valid && (!fifo_full || fifo_pop);
   assign ld_in     = '{rd: bus.ld_wb_rd, data: bus.ld_wb_data};
   assign wb_write  = (fpu_grant || ld_grant) && is_tracked(grant_wb.rd);

   fp_wb_fifo #(.DEPTH(LD_FIFO_DEPTH)) u_ld_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (ld_in),
      .pop   (fifo_pop),
      .dout  (ld_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // NOTE: every combinational output gets a default before any conditional
   // update, so no path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      grant_wb = ld_head;
      if (fpu_grant) grant_wb = '{rd: bus.fpu_wb_rd, data: bus.fpu_wb_data};

      busy_next = busy_q;
      if (fwb_en_q) busy_next[fwb_addr_q[FP_FLAG_BIT-1:0]] = 1'b0;
      if (fire && is_tracked(bus.issue_rd)) busy_next[bus.issue_rd[FP_FLAG_BIT-1:0]] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q        <= '0;
         starve_cnt    <= '0;
         fwb_en_q      <= 1'b0;
         fwb_addr_q    <= '0;
         fwb_data_q    <= '0;
         ld_overflow_q <= 1'b0;
      end else begin
         busy_q <= busy_next;

         if (!bus.fpu_wb_valid || fpu_grant) starve_cnt <= '0;
         else if (!starved)                  starve_cnt <= starve_cnt + 1'b1;

         // Untracked destinations are consumed silently; address/data keep
         // the last real write.
         fwb_en_q <= wb_write;
         if (wb_write) begin
            fwb_addr_q <= grant_wb.rd;
            fwb_data_q <= grant_wb.data;
         end

         if (bus.ld_wb_valid && !fifo_push) ld_overflow_q <= 1'b1;
      end
   end

   assign bus.issue_hazard = hazard;
   assign bus.issue_fire   = fire;
   assign bus.fpu_wb_ready = fpu_grant;
   assign bus.fwb_en       = fwb_en_q;
   assign bus.fwb_addr     = fwb_addr_q;
   assign bus.fwb_data     = fwb_data_q;
   assign bus.ld_overflow  = ld_overflow_q;
   assign bus.busy_vec     = busy_q;

endmodule
